// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared mode encodings and seed helper for the pattern generator
package seq_pkg;

  localparam logic [1:0] MODE_BIN  = 2'b00;
  localparam logic [1:0] MODE_RING = 2'b01;
  localparam logic [1:0] MODE_JOHN = 2'b10;
  localparam logic [1:0] MODE_GRAY = 2'b11;

  // Every seed is zero except bit 0, which is set only for the one-hot ring.
  // Returning just that bit keeps the helper independent of the channel count;
  // callers zero-extend it to their own width.
  function automatic logic seed_lsb(input logic [1:0] m);
    return (m == MODE_RING);
  endfunction

endpackage

// File: rtl/tick_div.sv
// rtl/tick_div.sv - programmable prescaler raising a terminal-count tick
module tick_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // Terminal count is combinational so the parent can register out and step together.
  assign tick = en && (cnt == div);

  // Count enabled cycles; clear has priority, and the count holds while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - N-channel binary/ring/Johnson/Gray pattern generator
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int N     = 3,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             oneshot,
  output logic [N-1:0]     out,
  output logic             step,
  output logic             wrap,
  output logic             busy
);

  logic [1:0]       mode_q;
  logic [DIV_W-1:0] div_q;
  logic             oneshot_q;
  logic [N-1:0]     cnt;
  logic [N-1:0]     cnt_next;
  logic [N-1:0]     out_next;
  logic [N-1:0]     seed_new;
  logic [N-1:0]     seed_run;
  logic             tick;
  logic             at_seed;

  // Prescaler only runs during an active, enabled run; start restarts it from zero.
  tick_div #(
    .DIV_W(DIV_W)
  ) u_tick_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start),
    .en   (busy && en),
    .div  (div_q),
    .tick (tick)
  );

  assign seed_new = N'(seed_lsb(mode));
  assign seed_run = N'(seed_lsb(mode_q));
  assign at_seed  = (out_next == seed_run);

  // Next pattern for the latched mode; Gray is derived from a hidden binary count.
  always_comb begin
    cnt_next = cnt + N'(1);
    out_next = out;
    case (mode_q)
      MODE_BIN:  out_next = out + N'(1);
      MODE_RING: out_next = {out[N-2:0], out[N-1]};
      MODE_JOHN: out_next = {out[N-2:0], ~out[N-1]};
      MODE_GRAY: out_next = cnt_next ^ (cnt_next >> 1);
      default:   out_next = out;
    endcase
  end

  // Run control: start reloads and wins over stepping; a tick advances the pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      step      <= 1'b0;
      wrap      <= 1'b0;
      busy      <= 1'b0;
      mode_q    <= MODE_BIN;
      div_q     <= '0;
      oneshot_q <= 1'b0;
      cnt       <= '0;
    end else if (start) begin
      mode_q    <= mode;
      div_q     <= div;
      oneshot_q <= oneshot;
      out       <= seed_new;
      cnt       <= '0;
      busy      <= 1'b1;
      step      <= 1'b0;
      wrap      <= 1'b0;
    end else if (tick) begin
      out  <= out_next;
      cnt  <= cnt_next;
      step <= 1'b1;
      wrap <= at_seed;
      if (at_seed && oneshot_q) begin
        busy <= 1'b0;
      end
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - directed vector bench for seq_pattern_gen
module tb_seq_pattern_gen;

  localparam int N     = 3;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             en;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic             oneshot;
  logic [N-1:0]     out;
  logic             step;
  logic             wrap;
  logic             busy;

  int checks = 0;
  int errors = 0;

  seq_pattern_gen #(
    .N    (N),
    .DIV_W(DIV_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .en     (en),
    .mode   (mode),
    .div    (div),
    .oneshot(oneshot),
    .out    (out),
    .step   (step),
    .wrap   (wrap),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       start;
    logic       en;
    logic [1:0] mode;
    logic [7:0] div;
    logic       oneshot;
    logic [2:0] e_out;
    logic       e_step;
    logic       e_wrap;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  // Inputs are driven 1 time unit after an edge; outputs are sampled 1 unit after the next edge.
  task automatic apply(input vec_t v);
    rst_n   = v.rst_n;
    start   = v.start;
    en      = v.en;
    mode    = v.mode;
    div     = v.div;
    oneshot = v.oneshot;
    @(posedge clk);
    #1;
    checks++;
    if ({out, step, wrap, busy} !== {v.e_out, v.e_step, v.e_wrap, v.e_busy}) begin
      errors++;
      $display("FAIL %s: got out=%b step=%b wrap=%b busy=%b, want out=%b step=%b wrap=%b busy=%b",
               v.name, out, step, wrap, busy, v.e_out, v.e_step, v.e_wrap, v.e_busy);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic r, input logic s, input logic e,
                              input logic [1:0] m, input logic [7:0] d, input logic o,
                              input logic [2:0] eo, input logic es, input logic ew, input logic eb);
    vec_t v;
    v.name = nm; v.rst_n = r; v.start = s; v.en = e; v.mode = m; v.div = d; v.oneshot = o;
    v.e_out = eo; v.e_step = es; v.e_wrap = ew; v.e_busy = eb;
    return v;
  endfunction

  task automatic add(input string nm, input logic r, input logic s, input logic e,
                     input logic [1:0] m, input logic [7:0] d, input logic o,
                     input logic [2:0] eo, input logic es, input logic ew, input logic eb);
    vecs.push_back(mk(nm, r, s, e, m, d, o, eo, es, ew, eb));
  endtask

  task automatic cyc(input string nm, input logic r, input logic s, input logic e,
                     input logic [1:0] m, input logic [7:0] d, input logic o,
                     input logic [2:0] eo, input logic es, input logic ew, input logic eb);
    apply(mk(nm, r, s, e, m, d, o, eo, es, ew, eb));
  endtask

  initial begin
    int bseq[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    int gseq[8] = '{1, 3, 2, 6, 7, 5, 4, 0};
    int rseq[3] = '{2, 4, 1};
    int jseq[6] = '{1, 3, 7, 6, 4, 0};
    logic [2:0] prev;

    rst_n = 1'b0; start = 1'b0; en = 1'b0; mode = 2'b00; div = '0; oneshot = 1'b0;
    #1;

    // Reset state
    add("reset0", 0, 0, 0, 2'b00, 8'd0, 0, 3'b000, 0, 0, 0);
    add("reset1", 0, 1, 1, 2'b01, 8'd5, 1, 3'b000, 0, 0, 0);

    // Binary, div=0, continuous; mode/div inputs scrambled after start must be ignored
    add("bin_start", 1, 1, 1, 2'b00, 8'd0, 0, 3'b000, 0, 0, 1);
    for (int i = 0; i < 9; i++)
      add("bin_step", 1, 0, 1, 2'b01, 8'd4, 1, 3'(bseq[i]), 1, (i == 7), 1);

    // Gray, div=1: one hold cycle then a step
    add("gray_start", 1, 1, 1, 2'b11, 8'd1, 0, 3'b000, 0, 0, 1);
    prev = 3'b000;
    for (int i = 0; i < 8; i++) begin
      add("gray_hold", 1, 0, 1, 2'b00, 8'd0, 0, prev, 0, 0, 1);
      add("gray_step", 1, 0, 1, 2'b00, 8'd0, 0, 3'(gseq[i]), 1, (i == 7), 1);
      prev = 3'(gseq[i]);
    end

    // Ring, div=2, continuous: step every third cycle
    add("ring_start", 1, 1, 1, 2'b01, 8'd2, 0, 3'b001, 0, 0, 1);
    prev = 3'b001;
    for (int i = 0; i < 3; i++) begin
      add("ring_hold", 1, 0, 1, 2'b10, 8'd0, 0, prev, 0, 0, 1);
      add("ring_hold", 1, 0, 1, 2'b10, 8'd0, 0, prev, 0, 0, 1);
      add("ring_step", 1, 0, 1, 2'b10, 8'd0, 0, 3'(rseq[i]), 1, (i == 2), 1);
      prev = 3'(rseq[i]);
    end
    add("ring_cont", 1, 0, 1, 2'b00, 8'd0, 0, 3'b001, 0, 0, 1);
    add("ring_cont", 1, 0, 1, 2'b00, 8'd0, 0, 3'b001, 0, 0, 1);
    add("ring_cont", 1, 0, 1, 2'b00, 8'd0, 0, 3'b010, 1, 0, 1);

    // Johnson one-shot, div=0: busy drops on the wrap step, then silence
    add("john_start", 1, 1, 1, 2'b10, 8'd0, 1, 3'b000, 0, 0, 1);
    for (int i = 0; i < 6; i++)
      add("john_step", 1, 0, 1, 2'b00, 8'd0, 0, 3'(jseq[i]), 1, (i == 5), (i != 5));
    for (int i = 0; i < 10; i++)
      add("john_idle", 1, 0, 1, 2'b00, 8'd0, 0, 3'b000, 0, 0, 0);

    foreach (vecs[i]) apply(vecs[i]);

    // Binary div=3 with en dropped for 5 cycles after two counted cycles
    cyc("pause_start", 1, 1, 1, 2'b00, 8'd3, 0, 3'b000, 0, 0, 1);
    cyc("pause_pre", 1, 0, 1, 2'b00, 8'd0, 0, 3'b000, 0, 0, 1);
    cyc("pause_pre", 1, 0, 1, 2'b00, 8'd0, 0, 3'b000, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      cyc("pause_frozen", 1, 0, 0, 2'b00, 8'd0, 0, 3'b000, 0, 0, 1);
    cyc("pause_resume", 1, 0, 1, 2'b00, 8'd0, 0, 3'b000, 0, 0, 1);
    cyc("pause_step", 1, 0, 1, 2'b00, 8'd0, 0, 3'b001, 1, 0, 1);
    for (int i = 0; i < 3; i++)
      cyc("pause_full_hold", 1, 0, 1, 2'b00, 8'd0, 0, 3'b001, 0, 0, 1);
    cyc("pause_full_step", 1, 0, 1, 2'b00, 8'd0, 0, 3'b010, 1, 0, 1);

    // Reset mid ring run, then a fresh binary run
    cyc("rr_start", 1, 1, 1, 2'b01, 8'd0, 0, 3'b001, 0, 0, 1);
    cyc("rr_step", 1, 0, 1, 2'b01, 8'd0, 0, 3'b010, 1, 0, 1);
    cyc("rr_step", 1, 0, 1, 2'b01, 8'd0, 0, 3'b100, 1, 0, 1);
    cyc("rr_reset", 0, 0, 1, 2'b01, 8'd0, 0, 3'b000, 0, 0, 0);
    cyc("rr_idle", 1, 0, 1, 2'b01, 8'd0, 0, 3'b000, 0, 0, 0);
    cyc("rr_idle", 1, 0, 1, 2'b01, 8'd0, 0, 3'b000, 0, 0, 0);
    cyc("rb_start", 1, 1, 1, 2'b00, 8'd0, 0, 3'b000, 0, 0, 1);
    cyc("rb_step", 1, 0, 1, 2'b00, 8'd0, 0, 3'b001, 1, 0, 1);
    cyc("rb_step", 1, 0, 1, 2'b00, 8'd0, 0, 3'b010, 1, 0, 1);

    // Start mid-run (with en low) reloads the ring seed without a step
    cyc("restart", 1, 1, 0, 2'b01, 8'd0, 0, 3'b001, 0, 0, 1);
    cyc("restart_hold", 1, 0, 0, 2'b00, 8'd0, 0, 3'b001, 0, 0, 1);
    cyc("restart_step", 1, 0, 1, 2'b00, 8'd0, 0, 3'b010, 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
